raid_rebuild_wr: RTL and testbench
==================================

RAID_REBUILD_WR -- requirements
Module: raid_rebuild_wr

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset: clk (posedge) and reset (asserted when 0).
REQ-002 Ports, in order:
- clk  in  1  system clock
- reset  in  1  async active-low reset
- mem_valid  in  1  one-cycle pulse from the read side: A/B data and address are valid
- rd_valid_data_A  in  12  surviving-disk codeword A
- rd_valid_data_B  in  12  surviving-disk codeword B
- add  in  8  block address of A/B
- disk_stat  in  3  disk health; exactly one 0 bit marks the failed disk
- last_op  in  1  pulse; the block now in flight is the final block
- mem_wr_ack  in  1  memory accepted the write
- wr_en  out  3  one-hot write enable to the failed disk
- wr_add  out  8  write address
- wr_data  out  12  rebuilt codeword
- write_done  out  1  one-cycle pulse: block finished, read side may advance
- rebuild_done  out  1  one-cycle pulse: final block written
- stat_err  out  1  one-cycle pulse: illegal disk_stat
- ovf_err  out  1  one-cycle pulse: mem_valid arrived while busy

Function
REQ-003 SHALL implement the FSM states IDLE, CALC, WRITE and DONE.
REQ-004 IDLE: on mem_valid with disk_stat in {110,101,011}, SHALL latch A, B, add and disk_stat, then go to CALC next cycle.
REQ-005 IDLE: on mem_valid with any other disk_stat, SHALL pulse stat_err, stay in IDLE, and issue no write and no write_done.
REQ-006 CALC: SHALL register wr_data = A XOR B (bitwise, 12 bits), then go to WRITE.
REQ-007 WRITE: SHALL drive wr_en, wr_add = latched add and wr_data, holding all three stable until the cycle mem_wr_ack=1.
- wr_en = 001 for disk_stat 110, 010 for 101, 100 for 011.
REQ-008 WRITE: in the mem_wr_ack cycle, SHALL go to DONE; wr_en SHALL be 000 from the next cycle.
REQ-009 DONE: SHALL assert write_done for exactly one cycle, then return to IDLE.
- Minimum latency, mem_valid to write_done = 4 cycles when mem_wr_ack is already high on the first WRITE cycle.
REQ-010 last_op SHALL set a sticky last_pending flag in any state.
REQ-011 In a DONE cycle with last_pending=1, SHALL also pulse rebuild_done in the same cycle and clear last_pending.
REQ-012 If last_op and DONE coincide, rebuild_done SHALL belong to the next completed block, not the current one.
REQ-013 mem_valid in CALC, WRITE or DONE SHALL be ignored (no state or data change) and SHALL pulse ovf_err.
REQ-014 mem_wr_ack outside WRITE SHALL be ignored.
REQ-015 All outputs SHALL be registered; write_done, rebuild_done, stat_err and ovf_err SHALL default to 0 in every cycle they are not pulsed.

Reset
REQ-016 While reset=0, SHALL hold the FSM in IDLE and clear:
- wr_en=000, wr_add=0, wr_data=0
- write_done=0, rebuild_done=0, stat_err=0, ovf_err=0
- last_pending=0, all latches=0
REQ-017 Reset asserted mid-WRITE SHALL drop wr_en asynchronously; no write_done SHALL follow release.
REQ-018 After release, the first mem_valid SHALL be handled from IDLE.

Configuration
REQ-019 Macro HAMMING_CHK_EN defined: in CALC, A and B SHALL each be Hamming(12,8) decoded before the XOR.
- Bit i = codeword position i+1; parity positions 1, 2, 4, 8.
- Syndrome 1..12: flip that position.
- Syndrome 13..15: set output uncorr_err (1 bit, sticky until reset); use the word uncorrected.
- Output corr_cnt[7:0] counts corrected words, saturating at 255.
- CALC becomes two cycles, so minimum latency = 5.
REQ-020 Macro undefined: raw XOR, ports uncorr_err and corr_cnt absent, latency per REQ-009.

Verification
REQ-021 Bench SHALL cover these directed scenarios:
- disk_stat=110, A=12'hA5C, B=12'h3F0, add=2, mem_wr_ack tied 1 -> wr_en=001, wr_add=2, wr_data=12'h9AC; write_done 4 cycles after mem_valid.
- disk_stat=011, mem_wr_ack delayed 5 cycles -> wr_en=100, wr_add/wr_data stable all 5 cycles; one write_done after ack.
- Four blocks, add 0..3, last_op pulsed before block 3 -> rebuild_done coincides only with block 3's write_done.
- disk_stat=111 or 100 with mem_valid -> stat_err pulse, wr_en stays 000, no write_done.
- mem_valid during WRITE -> ovf_err pulse; in-flight block still written unchanged.
- HAMMING_CHK_EN: A with position-5 bit flipped -> written data equals the clean-XOR result, corr_cnt=1.
- HAMMING_CHK_EN: A with syndrome 14 -> uncorr_err=1.
- reset=0 mid-WRITE -> wr_en=000 immediately; no write_done after release.

Source files
------------

// File: rtl/raid_rebuild_wr.sv
// -----------------------------------------------------------------------------
// raid_rebuild_wr
// Write side of a RAID rebuild engine. It takes two surviving-disk codewords
// (A, B) and a block address from the read side. It rebuilds the lost codeword
// as A XOR B and writes it to the failed disk, which is the single 0 bit of
// disk_stat. The write is held until memory acknowledges it. A one-cycle
// write_done pulse then lets the read side advance. rebuild_done marks the
// block that completes after last_op was seen.
//
// Optional build macro: HAMMING_CHK_EN
//   When defined, each codeword is Hamming(12,8) corrected in a first CALC
//   cycle, and the XOR happens in a second one. Ports uncorr_err and
//   corr_cnt are added.
//
// Ports
//   clk             system clock (posedge)
//   reset           asynchronous reset, active low
//   mem_valid       one-cycle pulse: A/B/add valid
//   rd_valid_data_A surviving codeword A
//   rd_valid_data_B surviving codeword B
//   add             block address
//   disk_stat       disk health, exactly one 0 bit marks the failed disk
//   last_op         pulse: block in flight is the final one
//   mem_wr_ack      memory accepted the write
//   wr_en           one-hot write enable to the failed disk
//   wr_add          write address
//   wr_data         rebuilt codeword
//   write_done      one-cycle pulse: block finished
//   rebuild_done    one-cycle pulse: final block written
//   stat_err        one-cycle pulse: illegal disk_stat
//   ovf_err         one-cycle pulse: mem_valid while busy
//   uncorr_err      (HAMMING_CHK_EN) sticky: uncorrected codeword seen
//   corr_cnt        (HAMMING_CHK_EN) corrected-word count, saturating
// -----------------------------------------------------------------------------
module raid_rebuild_wr (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic [11:0] rd_valid_data_A,
    input  logic [11:0] rd_valid_data_B,
    input  logic [7:0]  add,
    input  logic [2:0]  disk_stat,
    input  logic        last_op,
    input  logic        mem_wr_ack,
    output logic [2:0]  wr_en,
    output logic [7:0]  wr_add,
    output logic [11:0] wr_data,
    output logic        write_done,
    output logic        rebuild_done,
    output logic        stat_err,
    output logic        ovf_err
`ifdef HAMMING_CHK_EN
    ,
    output logic        uncorr_err,
    output logic [7:0]  corr_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, CALC, WRITE, DONE} state_t;

    state_t      state_r;
    logic [11:0] a_r;
    logic [11:0] b_r;
    logic [7:0]  add_r;
    logic [2:0]  stat_r;
    logic        last_pending_r;

    // A legal status has exactly one failed disk.
    function automatic logic stat_legal(input logic [2:0] s);
        logic ok;
        case (s)
            3'b110, 3'b101, 3'b011: ok = 1'b1;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    // The failed disk (the 0 bit) receives the write.
    function automatic logic [2:0] stat_to_en(input logic [2:0] s);
        logic [2:0] en;
        case (s)
            3'b110:  en = 3'b001;
            3'b101:  en = 3'b010;
            3'b011:  en = 3'b100;
            default: en = 3'b000;
        endcase
        return en;
    endfunction

`ifdef HAMMING_CHK_EN
    // Bit i holds codeword position i+1. Each syndrome bit is the parity of the
    // positions whose index has that bit set.
    function automatic logic [3:0] ham_syndrome(input logic [11:0] cw);
        logic [3:0] syn;
        syn[0] = ^(cw & 12'h555);
        syn[1] = ^(cw & 12'h666);
        syn[2] = ^(cw & 12'h878);
        syn[3] = ^(cw & 12'hF80);
        return syn;
    endfunction

    // Syndromes 1..12 name a single flipped position.
    function automatic logic ham_fixable(input logic [3:0] syn);
        return (syn >= 4'd1) && (syn <= 4'd12);
    endfunction

    function automatic logic [11:0] ham_correct(input logic [11:0] cw, input logic [3:0] syn);
        logic [11:0] fixed;
        if (ham_fixable(syn)) begin
            fixed = cw ^ (12'd1 << (syn - 4'd1));
        end else begin
            fixed = cw;
        end
        return fixed;
    endfunction

    logic       calc_phase_r;
    logic [3:0] syn_a_s;
    logic [3:0] syn_b_s;
    logic [1:0] fix_cnt_s;
    logic [8:0] cnt_sum_s;

    assign syn_a_s   = ham_syndrome(a_r);
    assign syn_b_s   = ham_syndrome(b_r);
    assign fix_cnt_s = {1'b0, ham_fixable(syn_a_s)} + {1'b0, ham_fixable(syn_b_s)};
    assign cnt_sum_s = {1'b0, corr_cnt} + {7'd0, fix_cnt_s};
`endif

    // Rebuild FSM with all outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r        <= IDLE;
            a_r            <= 12'd0;
            b_r            <= 12'd0;
            add_r          <= 8'd0;
            stat_r         <= 3'd0;
            last_pending_r <= 1'b0;
            wr_en          <= 3'b000;
            wr_add         <= 8'd0;
            wr_data        <= 12'd0;
            write_done     <= 1'b0;
            rebuild_done   <= 1'b0;
            stat_err       <= 1'b0;
            ovf_err        <= 1'b0;
`ifdef HAMMING_CHK_EN
            calc_phase_r   <= 1'b0;
            uncorr_err     <= 1'b0;
            corr_cnt       <= 8'd0;
`endif
        end else begin
            write_done   <= 1'b0;
            rebuild_done <= 1'b0;
            stat_err     <= 1'b0;
            ovf_err      <= 1'b0;

            // In DONE the old flag is consumed. A last_op arriving in that
            // same cycle re-arms the flag for the next block.
            if (state_r == DONE) begin
                last_pending_r <= last_op;
            end else if (last_op) begin
                last_pending_r <= 1'b1;
            end else begin
                last_pending_r <= last_pending_r;
            end

            if (mem_valid && (state_r != IDLE)) begin
                ovf_err <= 1'b1;
            end

            case (state_r)
                IDLE: begin
                    if (mem_valid) begin
                        if (stat_legal(disk_stat)) begin
                            a_r     <= rd_valid_data_A;
                            b_r     <= rd_valid_data_B;
                            add_r   <= add;
                            stat_r  <= disk_stat;
                            state_r <= CALC;
                        end else begin
                            stat_err <= 1'b1;
                        end
                    end
                end
                CALC: begin
`ifdef HAMMING_CHK_EN
                    if (!calc_phase_r) begin
                        a_r          <= ham_correct(a_r, syn_a_s);
                        b_r          <= ham_correct(b_r, syn_b_s);
                        calc_phase_r <= 1'b1;
                        if (!ham_fixable(syn_a_s) && (syn_a_s != 4'd0)) begin
                            uncorr_err <= 1'b1;
                        end
                        if (!ham_fixable(syn_b_s) && (syn_b_s != 4'd0)) begin
                            uncorr_err <= 1'b1;
                        end
                        corr_cnt <= cnt_sum_s[8] ? 8'd255 : cnt_sum_s[7:0];
                    end else begin
                        calc_phase_r <= 1'b0;
                        wr_data      <= a_r ^ b_r;
                        wr_add       <= add_r;
                        wr_en        <= stat_to_en(stat_r);
                        state_r      <= WRITE;
                    end
`else
                    wr_data <= a_r ^ b_r;
                    wr_add  <= add_r;
                    wr_en   <= stat_to_en(stat_r);
                    state_r <= WRITE;
`endif
                end
                WRITE: begin
                    if (mem_wr_ack) begin
                        wr_en   <= 3'b000;
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    write_done   <= 1'b1;
                    rebuild_done <= last_pending_r;
                    state_r      <= IDLE;
                end
                default: begin
                    wr_en   <= 3'b000;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_raid_rebuild_wr.sv
// -----------------------------------------------------------------------------
// tb_raid_rebuild_wr
// Self-checking bench for raid_rebuild_wr. A small behavioural model provides
// the expected values. It gives the enable as the position of the 0 bit in
// disk_stat, the rebuilt word as A XOR B (after correction when
// HAMMING_CHK_EN is defined), a pending-last flag, and a fixed latency.
// -----------------------------------------------------------------------------
module tb_raid_rebuild_wr;

`ifdef HAMMING_CHK_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 4;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_valid = 1'b0;
    logic [11:0] rd_valid_data_A = 12'd0;
    logic [11:0] rd_valid_data_B = 12'd0;
    logic [7:0]  add = 8'd0;
    logic [2:0]  disk_stat = 3'b111;
    logic        last_op = 1'b0;
    logic        mem_wr_ack = 1'b0;
    logic [2:0]  wr_en;
    logic [7:0]  wr_add;
    logic [11:0] wr_data;
    logic        write_done, rebuild_done, stat_err, ovf_err;
`ifdef HAMMING_CHK_EN
    logic        uncorr_err;
    logic [7:0]  corr_cnt;
`endif

    int total = 0;
    int bad = 0;
    bit pend_m = 1'b0;

    always #5 clk = ~clk;

    raid_rebuild_wr dut (
        .clk(clk), .reset(reset), .mem_valid(mem_valid),
        .rd_valid_data_A(rd_valid_data_A), .rd_valid_data_B(rd_valid_data_B),
        .add(add), .disk_stat(disk_stat), .last_op(last_op), .mem_wr_ack(mem_wr_ack),
        .wr_en(wr_en), .wr_add(wr_add), .wr_data(wr_data),
        .write_done(write_done), .rebuild_done(rebuild_done),
        .stat_err(stat_err), .ovf_err(ovf_err)
`ifdef HAMMING_CHK_EN
        , .uncorr_err(uncorr_err), .corr_cnt(corr_cnt)
`endif
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Model: the write goes to the disk whose status bit is 0.
    function automatic logic [2:0] model_en(input logic [2:0] st);
        logic [2:0] en = 3'b000;
        for (int i = 0; i < 3; i++) if (st[i] == 1'b0) en = en | 3'(1 << i);
        return en;
    endfunction

    // Model: syndrome = XOR of the positions (1..12) of all set bits.
    function automatic int model_syn(input logic [11:0] cw);
        int s = 0;
        for (int p = 1; p <= 12; p++)
            if (((int'(cw) >> (p - 1)) & 1) == 1) s = s ^ p;
        return s;
    endfunction

    function automatic logic [11:0] model_fix(input logic [11:0] cw);
`ifdef HAMMING_CHK_EN
        int s = model_syn(cw);
        if (s >= 1 && s <= 12) return cw ^ 12'(1 << (s - 1));
        return cw;
`else
        return cw;
`endif
    endfunction

    // Data in positions 3,5,6,7,9,10,11,12; parity fixed so the syndrome is 0.
    function automatic logic [11:0] model_enc(input logic [7:0] d);
        logic [11:0] cw = {d[7:4], 1'b0, d[3:1], 1'b0, d[0], 2'b00};
        int s = model_syn(cw);
        for (int k = 0; k < 4; k++)
            if (((s >> k) & 1) == 1) cw = cw ^ 12'(1 << ((1 << k) - 1));
        return cw;
    endfunction

    function automatic logic [11:0] rand_word;
`ifdef HAMMING_CHK_EN
        return model_enc(8'($urandom_range(0, 255)));
`else
        return 12'($urandom_range(0, 4095));
`endif
    endfunction

    task automatic pulse_last;
        last_op = 1'b1;
        step;
        last_op = 1'b0;
        pend_m = 1'b1;
    endtask

    // One block through the write path. dly = cycles of withheld ack.
    task automatic run_block(input logic [11:0] a, input logic [11:0] b, input logic [7:0] ad,
                             input logic [2:0] st, input int dly, input bit last_in_done);
        logic [2:0]  exp_en = model_en(st);
        logic [11:0] exp_d  = model_fix(a) ^ model_fix(b);
        bit          exp_rb;
        int          edges;
        rd_valid_data_A = a; rd_valid_data_B = b; add = ad; disk_stat = st;
        mem_valid = 1'b1;
        step;
        mem_valid = 1'b0;
        edges = 1;
        while (wr_en === 3'b000 && edges < 20) begin
            step;
            edges++;
        end
        total++; if (edges != LAT - 2) begin bad++; $display("FAIL write_start: edges=%0d want=%0d", edges, LAT - 2); end
        total++; if (wr_en !== exp_en) begin bad++; $display("FAIL wr_en: got=%b want=%b", wr_en, exp_en); end
        total++; if (wr_add !== ad) begin bad++; $display("FAIL wr_add: got=%h want=%h", wr_add, ad); end
        total++; if (wr_data !== exp_d) begin bad++; $display("FAIL wr_data: got=%h want=%h", wr_data, exp_d); end
        for (int i = 0; i < dly; i++) begin
            step;
            edges++;
            total++;
            if ({wr_en, wr_add, wr_data} !== {exp_en, ad, exp_d}) begin
                bad++; $display("FAIL write_hold: cycle=%0d got=%b/%h/%h want=%b/%h/%h",
                                i, wr_en, wr_add, wr_data, exp_en, ad, exp_d);
            end
        end
        mem_wr_ack = 1'b1;
        step;
        edges++;
        mem_wr_ack = 1'b0;
        if (last_in_done) last_op = 1'b1;
        total++; if (wr_en !== 3'b000) begin bad++; $display("FAIL wr_en_clear: got=%b want=000", wr_en); end
        step;
        edges++;
        last_op = 1'b0;
        total++;
        if (write_done !== 1'b1 || edges != LAT + dly) begin
            bad++; $display("FAIL write_done: got=%b edges=%0d want=1 edges=%0d", write_done, edges, LAT + dly);
        end
        exp_rb = pend_m;
        pend_m = last_in_done;
        total++; if (rebuild_done !== exp_rb) begin bad++; $display("FAIL rebuild_done: got=%b want=%b", rebuild_done, exp_rb); end
        step;
        total++;
        if (write_done !== 1'b0 || rebuild_done !== 1'b0) begin
            bad++; $display("FAIL pulse_width: wd=%b rb=%b want=0/0", write_done, rebuild_done);
        end
    endtask

    task automatic test_reset;
        #3 reset = 1'b0;
        step;
        step;
        total++; if (wr_en !== 3'b000) begin bad++; $display("FAIL rst_wr_en: got=%b want=000", wr_en); end
        total++; if (wr_add !== 8'd0 || wr_data !== 12'd0) begin bad++; $display("FAIL rst_addr_data: got=%h/%h want=0/0", wr_add, wr_data); end
        total++;
        if ({write_done, rebuild_done, stat_err, ovf_err} !== 4'b0000) begin
            bad++; $display("FAIL rst_pulses: got=%b want=0000", {write_done, rebuild_done, stat_err, ovf_err});
        end
`ifdef HAMMING_CHK_EN
        total++; if (uncorr_err !== 1'b0 || corr_cnt !== 8'd0) begin bad++; $display("FAIL rst_ham: got=%b/%0d want=0/0", uncorr_err, corr_cnt); end
`endif
        reset = 1'b1;
        pend_m = 1'b0;
        step;
    endtask

    task automatic test_basic;
        run_block(model_enc(8'h00) ^ 12'hA5C ^ model_enc(8'h00), 12'h3F0, 8'd2, 3'b110, 0, 1'b0);
    endtask

    task automatic test_delayed_ack;
        run_block(rand_word(), rand_word(), 8'h40, 3'b011, 5, 1'b0);
    endtask

    task automatic test_last_op;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) pulse_last();
            run_block(rand_word(), rand_word(), 8'(i), 3'b101, 0, 1'b0);
        end
        // last_op landing on a DONE cycle belongs to the following block.
        run_block(rand_word(), rand_word(), 8'h10, 3'b110, 1, 1'b1);
        run_block(rand_word(), rand_word(), 8'h11, 3'b110, 0, 1'b0);
    endtask

    task automatic test_stat_err;
        logic [2:0] bad_st [2] = '{3'b111, 3'b100};
        for (int k = 0; k < 2; k++) begin
            mem_wr_ack = 1'b1;
            disk_stat = bad_st[k];
            rd_valid_data_A = rand_word(); rd_valid_data_B = rand_word(); add = 8'h77;
            mem_valid = 1'b1;
            step;
            mem_valid = 1'b0;
            total++; if (stat_err !== 1'b1) begin bad++; $display("FAIL stat_err: stat=%b got=%b want=1", bad_st[k], stat_err); end
            for (int i = 0; i < 6; i++) begin
                step;
                total++;
                if ({wr_en, write_done, stat_err} !== 5'b00000) begin
                    bad++; $display("FAIL stat_quiet: en=%b wd=%b se=%b want=000/0/0", wr_en, write_done, stat_err);
                end
            end
            mem_wr_ack = 1'b0;
        end
    endtask

    task automatic test_overflow;
        logic [11:0] a = rand_word();
        logic [11:0] b = rand_word();
        logic [11:0] exp_d = model_fix(a) ^ model_fix(b);
        int cyc = 0;
        bit exp_rb;
        rd_valid_data_A = a; rd_valid_data_B = b; add = 8'h5A; disk_stat = 3'b101;
        mem_valid = 1'b1;
        step;
        mem_valid = 1'b0;
        while (wr_en === 3'b000 && cyc < 20) begin step; cyc++; end
        rd_valid_data_A = ~a; rd_valid_data_B = b ^ 12'h0F0; add = 8'hA5; disk_stat = 3'b110;
        mem_valid = 1'b1;
        step;
        mem_valid = 1'b0;
        total++; if (ovf_err !== 1'b1) begin bad++; $display("FAIL ovf_err: got=%b want=1", ovf_err); end
        total++;
        if ({wr_en, wr_add, wr_data} !== {3'b010, 8'h5A, exp_d}) begin
            bad++; $display("FAIL ovf_hold: got=%b/%h/%h want=010/5a/%h", wr_en, wr_add, wr_data, exp_d);
        end
        step;
        total++; if (ovf_err !== 1'b0) begin bad++; $display("FAIL ovf_width: got=%b want=0", ovf_err); end
        mem_wr_ack = 1'b1;
        step;
        mem_wr_ack = 1'b0;
        step;
        exp_rb = pend_m;
        pend_m = 1'b0;
        total++;
        if (write_done !== 1'b1 || rebuild_done !== exp_rb || wr_data !== exp_d) begin
            bad++; $display("FAIL ovf_done: wd=%b rb=%b data=%h want=1/%b/%h", write_done, rebuild_done, wr_data, exp_rb, exp_d);
        end
        step;
    endtask

    task automatic test_reset_mid_write;
        int cyc = 0;
        bit seen = 1'b0;
        rd_valid_data_A = rand_word(); rd_valid_data_B = rand_word(); add = 8'h33; disk_stat = 3'b011;
        mem_valid = 1'b1;
        step;
        mem_valid = 1'b0;
        while (wr_en === 3'b000 && cyc < 20) begin step; cyc++; end
        #2 reset = 1'b0;
        #1;
        total++; if (wr_en !== 3'b000) begin bad++; $display("FAIL async_clear: got=%b want=000", wr_en); end
        pend_m = 1'b0;
        step;
        step;
        reset = 1'b1;
        mem_wr_ack = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step;
            if (write_done === 1'b1 || wr_en !== 3'b000) seen = 1'b1;
        end
        mem_wr_ack = 1'b0;
        total++; if (seen) begin bad++; $display("FAIL post_reset_quiet: activity=1 want=0"); end
        run_block(rand_word(), rand_word(), 8'h34, 3'b110, 0, 1'b0);
    endtask

    task automatic test_random;
        logic [2:0] legal [3] = '{3'b110, 3'b101, 3'b011};
        for (int n = 0; n < 12; n++) begin
            if ($urandom_range(0, 3) == 0) pulse_last();
            run_block(rand_word(), rand_word(), 8'($urandom_range(0, 255)),
                      legal[$urandom_range(0, 2)], int'($urandom_range(0, 3)),
                      ($urandom_range(0, 5) == 0));
        end
    endtask

`ifdef HAMMING_CHK_EN
    task automatic test_hamming;
        logic [11:0] a = model_enc(8'h5A);
        logic [11:0] b = model_enc(8'hC3);
        test_reset();
        run_block(a ^ 12'h010, b, 8'h21, 3'b110, 0, 1'b0);
        total++; if (wr_data !== (a ^ b)) begin bad++; $display("FAIL ham_fix_data: got=%h want=%h", wr_data, a ^ b); end
        total++; if (corr_cnt !== 8'd1) begin bad++; $display("FAIL ham_corr_cnt: got=%0d want=1", corr_cnt); end
        total++; if (uncorr_err !== 1'b0) begin bad++; $display("FAIL ham_no_uncorr: got=%b want=0", uncorr_err); end
        run_block(a ^ 12'h0A0, b, 8'h22, 3'b101, 0, 1'b0);
        total++; if (uncorr_err !== 1'b1) begin bad++; $display("FAIL ham_uncorr: got=%b want=1", uncorr_err); end
        total++; if (corr_cnt !== 8'd1) begin bad++; $display("FAIL ham_cnt_hold: got=%0d want=1", corr_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_delayed_ack();
        test_last_op();
        test_stat_err();
        test_overflow();
        test_reset_mid_write();
        test_random();
`ifdef HAMMING_CHK_EN
        test_hamming();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
